// File: rtl/fpu_addsub_param.sv
// fpu_addsub_param: multi-cycle parametrised floating-point adder/subtractor.
// Word = {sign, EXP_W unbiased exponent, MAN_W fraction} with an implicit
// leading 1; exponent=0 and fraction=0 encodes zero (either sign).
// Rounding is round-to-nearest-even using guard/round/sticky bits.
// Build option FPU_FLUSH_INEXACT_EN: inexact results are flushed to zero.
module fpu_addsub_param #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25
) (
    input  logic                 clock100KHz,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic [EXP_W+MAN_W:0] op_A_in,
    input  logic [EXP_W+MAN_W:0] op_B_in,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] data_out,
    output logic [3:0]           status_out
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1;   // hidden bit + fraction
    localparam int AW = MAN_W + 3;   // hidden, fraction, guard, round
    localparam int WW = MAN_W + 5;   // carry, hidden, fraction, guard, round, sticky
    localparam int XW = EXP_W + 1;   // exponent with headroom for the carry shift
    localparam logic [EXP_W-1:0] D_MAX = EXP_W'(MAN_W + 2);
    localparam logic [XW-1:0]    E_OVF = XW'((1 << EXP_W) - 1);

`ifdef FPU_FLUSH_INEXACT_EN
    localparam bit FLUSH_INEXACT = 1'b1;
`else
    localparam bit FLUSH_INEXACT = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_OPER, S_NORM, S_ROUND, S_OUT} state_t;
    state_t state, state_nxt;

    logic             accept;
    logic             sgn_a, sgn_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MW-1:0]    man_a, man_b;
    logic [AW-1:0]    big_al, sml_al;
    logic             stk, big_sgn, sml_sgn;
    logic [XW-1:0]    exp_r;
    logic [WW-1:0]    mag;
    logic             sgn_r, zero_r, uf_r, inx_r;
    logic [MAN_W-1:0] frac_r;

    logic             a_ge, al_stk, sgn_sum, norm_exit;
    logic [EXP_W-1:0] d_sh;
    logic [AW-1:0]    sml_ext, al_sml;
    logic [2*AW-1:0]  al_full;
    logic [WW-1:0]    big_x, sml_x, mag_sum;
    logic [MAN_W+1:0] rnd;

    // Mantissa with hidden bit; the zero encoding gets no implicit 1
    function automatic logic [MW-1:0] unpack_man(input logic [W-1:0] x);
        logic nz;
        nz = (x[W-2:MAN_W] != '0) || (x[MAN_W-1:0] != '0);
        return {nz, x[MAN_W-1:0]};
    endfunction

    // Round-to-nearest-even: returns {inexact, carry_out, rounded fraction}
    function automatic logic [MAN_W+1:0] rne(input logic [WW-1:0] m);
        logic up;
        up = m[2] & (m[1] | m[0] | m[3]);
        return {m[2] | m[1] | m[0], up & (&m[WW-2:3]), m[MAN_W+2:3] + MAN_W'(up)};
    endfunction

    // Final saturation/flush and status encoding: returns {word, status}
    function automatic logic [W+3:0] pack_result(input logic sgn, input logic [XW-1:0] e,
                                                 input logic [MAN_W-1:0] f,
                                                 input logic zero, input logic uf,
                                                 input logic inx);
        logic [W-1:0] word;
        word = {sgn, e[EXP_W-1:0], f};
        if (e >= E_OVF)
            return {{W{1'b0}}, 4'b0100};
        else if (uf)
            return {{W{1'b0}}, 4'b1000};
        else if (zero)
            return {{W{1'b0}}, 4'b0001};
        else if (inx)
            return {(FLUSH_INEXACT ? {W{1'b0}} : word), 4'b0010};
        return {word, 4'b0001};
    endfunction

    // Align: shift the smaller-exponent mantissa right, OR shifted-out bits into sticky
    always_comb begin
        a_ge    = exp_a >= exp_b;
        d_sh    = a_ge ? exp_a - exp_b : exp_b - exp_a;
        sml_ext = a_ge ? {man_b, 2'b00} : {man_a, 2'b00};
        al_full = {sml_ext, {AW{1'b0}}} >> d_sh;
        if (d_sh > D_MAX) begin
            al_sml = '0;
            al_stk = |sml_ext;
        end else begin
            al_sml = al_full[2*AW-1:AW];
            al_stk = |al_full[AW-1:0];
        end
    end

    // Magnitude add or subtract; sticky rides as the LSB so borrows see it
    always_comb begin
        big_x = {1'b0, big_al, 1'b0};
        sml_x = {1'b0, sml_al, stk};
        if (big_sgn == sml_sgn) begin
            mag_sum = big_x + sml_x;
            sgn_sum = big_sgn;
        end else if (big_x >= sml_x) begin
            mag_sum = big_x - sml_x;
            sgn_sum = big_sgn;
        end else begin
            mag_sum = sml_x - big_x;
            sgn_sum = sml_sgn;
        end
        if (mag_sum == '0)
            sgn_sum = 1'b0;
    end

    assign rnd       = rne(mag);
    assign norm_exit = zero_r || (!mag[WW-1] && (mag[WW-2] || exp_r == '0));

    // State register
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; NORM loops one shift per cycle until normalized
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_ALIGN;
            S_ALIGN: state_nxt = S_OPER;
            S_OPER:  state_nxt = S_NORM;
            S_NORM:  if (norm_exit) state_nxt = S_ROUND;
            S_ROUND: state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: busy in every non-idle state, operands accepted only from idle
    always_comb begin
        busy   = (state != S_IDLE);
        accept = (state == S_IDLE) && start;
    end

    // Datapath registers, advanced per state
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            sgn_a <= 1'b0;  sgn_b <= 1'b0;
            exp_a <= '0;    exp_b <= '0;
            man_a <= '0;    man_b <= '0;
            big_al <= '0;   sml_al <= '0;
            stk <= 1'b0;    big_sgn <= 1'b0;  sml_sgn <= 1'b0;
            exp_r <= '0;    mag <= '0;
            sgn_r <= 1'b0;  zero_r <= 1'b0;   uf_r <= 1'b0;  inx_r <= 1'b0;
            frac_r <= '0;
            data_out <= '0; status_out <= '0; done <= 1'b0;
        end else begin
            done <= (state == S_OUT);
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        sgn_a <= op_A_in[W-1];
                        sgn_b <= op_B_in[W-1] ^ op_sub;
                        exp_a <= op_A_in[W-2:MAN_W];
                        exp_b <= op_B_in[W-2:MAN_W];
                        man_a <= unpack_man(op_A_in);
                        man_b <= unpack_man(op_B_in);
                        uf_r  <= 1'b0;
                    end
                end
                S_ALIGN: begin
                    big_al  <= a_ge ? {man_a, 2'b00} : {man_b, 2'b00};
                    sml_al  <= al_sml;
                    stk     <= al_stk;
                    big_sgn <= a_ge ? sgn_a : sgn_b;
                    sml_sgn <= a_ge ? sgn_b : sgn_a;
                    exp_r   <= {1'b0, (a_ge ? exp_a : exp_b)};
                end
                S_OPER: begin
                    mag    <= mag_sum;
                    sgn_r  <= sgn_sum;
                    zero_r <= (mag_sum == '0);
                end
                S_NORM: begin
                    if (!zero_r) begin
                        if (mag[WW-1]) begin
                            mag   <= {1'b0, mag[WW-1:2], mag[1] | mag[0]};
                            exp_r <= exp_r + XW'(1);
                        end else if (!mag[WW-2]) begin
                            if (exp_r == '0) begin
                                uf_r <= 1'b1;
                            end else begin
                                mag   <= mag << 1;
                                exp_r <= exp_r - XW'(1);
                            end
                        end
                    end
                end
                S_ROUND: begin
                    frac_r <= rnd[MAN_W-1:0];
                    exp_r  <= exp_r + {{EXP_W{1'b0}}, rnd[MAN_W]};
                    inx_r  <= rnd[MAN_W+1];
                end
                S_OUT: begin
                    {data_out, status_out} <= pack_result(sgn_r, exp_r, frac_r, zero_r, uf_r, inx_r);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addsub_param.sv
`timescale 1ns/1ps
module tb_fpu_addsub_param;
    localparam int EXP_W = 6;
    localparam int MAN_W = 25;

`ifdef FPU_FLUSH_INEXACT_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clock100KHz = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic [31:0] op_A_in = '0;
    logic [31:0] op_B_in = '0;
    logic        busy, done;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct packed { logic [31:0] data; logic [3:0] status; } exp_t;
    exp_t exp_q[$];

    typedef struct packed {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [3:0]  s;
        logic [7:0]  lat;
    } vec_t;

    fpu_addsub_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clock100KHz(clock100KHz),
        .reset(reset),
        .start(start),
        .op_sub(op_sub),
        .op_A_in(op_A_in),
        .op_B_in(op_B_in),
        .busy(busy),
        .done(done),
        .data_out(data_out),
        .status_out(status_out)
    );

    always #5 clock100KHz = ~clock100KHz;

    always @(posedge clock100KHz) if (done === 1'b1) done_cnt <= done_cnt + 1;

    // Drive one operation; returns #1 after the accept edge
    task automatic issue(input logic sub, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic [3:0] s);
        @(negedge clock100KHz);
        start = 1'b1; op_sub = sub; op_A_in = a; op_B_in = b;
        exp_q.push_back('{data: d, status: s});
        @(posedge clock100KHz);
        #1 start = 1'b0;
    endtask

    // Edges until done is seen high; -1 when the budget runs out
    task automatic wait_done(input int budget, output int lat);
        bit got;
        got = 1'b0;
        lat = -1;
        for (int c = 1; c <= budget && !got; c++) begin
            @(posedge clock100KHz);
            #1;
            if (done === 1'b1) begin
                got = 1'b1;
                lat = c;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clock100KHz);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", data_out); end
        checks++; if (status_out !== 4'b0000) begin errors++; $display("FAIL reset_status: got %b want 0000", status_out); end
        reset = 1'b1;
    endtask

    task automatic test_arith;
        vec_t v[13];
        exp_t e;
        int lat;
        v[0]  = '{1'b0, 32'h14000000, 32'h14000000, 32'h16000000, 4'b0001, 8'd6};
        v[1]  = '{1'b1, 32'h14000000, 32'h14000000, 32'h00000000, 4'b0001, 8'd5};
        v[2]  = '{1'b0, 32'h7C000000, 32'h7C000000, 32'h00000000, 4'b0100, 8'd6};
        v[3]  = '{1'b0, 32'h18000000, 32'h14000001, (FLUSH ? 32'h0 : 32'h18800000), 4'b0010, 8'd5};
        v[4]  = '{1'b1, 32'h02000001, 32'h02000000, 32'h00000000, 4'b1000, 8'd6};
        v[5]  = '{1'b0, 32'h14000000, 32'h00000000, 32'h14000000, 4'b0001, 8'd5};
        v[6]  = '{1'b1, 32'h14000000, 32'h16000000, 32'h94000000, 4'b0001, 8'd6};
        v[7]  = '{1'b0, 32'h18000000, 32'h14000003, (FLUSH ? 32'h0 : 32'h18800001), 4'b0010, 8'd5};
        v[8]  = '{1'b0, 32'h18000000, 32'h14000002, (FLUSH ? 32'h0 : 32'h18800000), 4'b0010, 8'd5};
        v[9]  = '{1'b0, 32'h37FFFFFF, 32'h02000000, (FLUSH ? 32'h0 : 32'h38000000), 4'b0010, 8'd5};
        v[10] = '{1'b0, 32'h38000000, 32'h00000001, (FLUSH ? 32'h0 : 32'h38000000), 4'b0010, 8'd5};
        v[11] = '{1'b1, 32'h38000000, 32'h00000001, (FLUSH ? 32'h0 : 32'h38000000), 4'b0010, 8'd6};
        v[12] = '{1'b0, 32'h80000000, 32'h00000000, 32'h00000000, 4'b0001, 8'd5};
        for (int i = 0; i < 13; i++) begin
            issue(v[i].sub, v[i].a, v[i].b, v[i].d, v[i].s);
            wait_done(80, lat);
            e = exp_q.pop_front();
            checks++; if (lat != int'(v[i].lat)) begin errors++; $display("FAIL arith%0d_latency: got %0d want %0d", i, lat, v[i].lat); end
            checks++; if (data_out !== e.data) begin errors++; $display("FAIL arith%0d_data: got %h want %h", i, data_out, e.data); end
            checks++; if (status_out !== e.status) begin errors++; $display("FAIL arith%0d_status: got %b want %b", i, status_out, e.status); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arith%0d_busy: got %b want 0", i, busy); end
        end
    endtask

    task automatic test_busy_ignore;
        exp_t e;
        int lat, d0;
        issue(1'b0, 32'h14000000, 32'h14000000, 32'h16000000, 4'b0001);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_high: got %b want 1", busy); end
        @(negedge clock100KHz);
        start = 1'b1; op_sub = 1'b1; op_A_in = 32'h7C000000; op_B_in = 32'h02000000;
        @(posedge clock100KHz);
        #1 start = 1'b0;
        wait_done(80, lat);
        e = exp_q.pop_front();
        checks++; if (lat != 5) begin errors++; $display("FAIL busy_latency: got %0d want 5", lat); end
        checks++; if (data_out !== e.data) begin errors++; $display("FAIL busy_data: got %h want %h", data_out, e.data); end
        checks++; if (status_out !== e.status) begin errors++; $display("FAIL busy_status: got %b want %b", status_out, e.status); end
        @(posedge clock100KHz);
        #1 d0 = done_cnt;
        repeat (12) @(posedge clock100KHz);
        #1;
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL busy_extra_done: got %0d want %0d", done_cnt, d0); end
        checks++; if (data_out !== 32'h16000000) begin errors++; $display("FAIL busy_data_held: got %h want 16000000", data_out); end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int lat, d0;
        issue(1'b1, 32'h14000001, 32'h14000000, 32'h00000000, 4'b1000);
        repeat (3) @(posedge clock100KHz);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h want 00000000", data_out); end
        checks++; if (status_out !== 4'b0000) begin errors++; $display("FAIL midrst_status: got %b want 0000", status_out); end
        d0 = done_cnt;
        repeat (2) @(negedge clock100KHz);
        reset = 1'b1;
        repeat (20) @(posedge clock100KHz);
        #1;
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL midrst_no_done: got %0d want %0d", done_cnt, d0); end
        issue(1'b0, 32'h14000000, 32'h14000000, 32'h16000000, 4'b0001);
        wait_done(80, lat);
        e = exp_q.pop_front();
        checks++; if (lat != 6) begin errors++; $display("FAIL midrst_latency: got %0d want 6", lat); end
        checks++; if (data_out !== e.data) begin errors++; $display("FAIL midrst_data_after: got %h want %h", data_out, e.data); end
        checks++; if (status_out !== e.status) begin errors++; $display("FAIL midrst_status_after: got %b want %b", status_out, e.status); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
